dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
Write-side buffer placed directly upstream of the data memory in the MEM stage. It accepts store operations from the EX/MEM pipeline register, queues them in a small in-order FIFO, and drains one store per cycle into the data memory write port whenever that port is not busy with a load. It also gives load forwarding, so a load always sees the youngest pending store to its address.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2
DATA_W, 8, data width; equals the shared byte width constant
ADDR_W, 8, address width; 256-entry data memory

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
st_valid  in  1  a store is presented this cycle
st_addr  in  ADDR_W  store address
st_data  in  DATA_W  store data
st_ready  out  1  buffer can accept a store this cycle (equals not full)
ld_addr  in  ADDR_W  address of the load currently in the MEM stage
ld_hit  out  1  a pending store matches ld_addr (combinational)
ld_data  out  DATA_W  data of the youngest matching entry; 0 when ld_hit=0
mem_busy  in  1  the memory port is claimed by a load this cycle; no drain
mem_wrt  out  1  to data memory write enable
mem_addr  out  ADDR_W  to data memory address
mem_data  out  DATA_W  to data memory write data
count  out  $clog2(DEPTH+1)  number of occupied entries
empty  out  1  count == 0

Behaviour:
- Reset (rst_n=0, asynchronous): head=tail=0, count=0, all entry-valid bits cleared. Outputs are then: empty=1, st_ready=1, mem_wrt=0, ld_hit=0, ld_data=0, mem_addr=0, mem_data=0. Reset mid-drain discards all pending stores; no write is issued in the reset cycle.
- Storage: circular FIFO of DEPTH entries {valid, addr, data}; head and tail pointers are log2(DEPTH) bits and wrap naturally.
- Push: fires at the rising edge when st_valid && st_ready. The entry is written at tail, then tail++. If st_valid is asserted while full, the store is ignored; the upstream stage must hold it, and st_ready=0 tells it to.
- Drain (combinational from head): mem_wrt = !empty && !mem_busy; mem_addr and mem_data come from the head entry. When mem_wrt=0, mem_addr and mem_data are 0.
- Pop: at the same rising edge the memory commits the write (mem_wrt=1), the head entry is invalidated and head++.
- Latency: a store pushed at edge N reaches memory at edge N+1 at the earliest. There is no push-through to memory when the buffer is empty.
- Simultaneous push and pop: count is unchanged, and this is legal at any count < DEPTH. At count==DEPTH, st_ready=0 even if a pop occurs that cycle; this is a registered-full decision with no combinational ready-from-pop path.
- Order: memory writes occur strictly in push order. Same-address stores are not coalesced.
- Forwarding: all valid entries are compared with ld_addr.
  - ld_hit=1 if any entry matches.
  - ld_data comes from the youngest match, meaning the one closest to tail-1, scanning backwards with wrap.
  - The head entry being drained this cycle still participates.
  - The store presented on st_* in the same cycle is NOT visible to forwarding.
- Counter: count increments on push-only, decrements on pop-only, and never exceeds DEPTH or goes below 0.

Decomposition:
- Shared package (Definitions): the byte width, memory address width, and a store-entry struct typedef {valid, addr, data}.
- One sub-module: store_buf_match, a combinational youngest-match priority search. Inputs are the entry array, tail, and ld_addr. Outputs are hit and data.

Test Plan:
- Reset: hold rst_n=0 while driving random inputs -> empty=1, count=0, st_ready=1, mem_wrt=0, ld_hit=0. Deassert rst_n -> state unchanged until the first push.
- Single store: push addr 0x10, data 0xAB with mem_busy=0 -> next cycle mem_wrt=1, mem_addr=0x10, mem_data=0xAB. Following cycle empty=1 and memory[0x10]=0xAB.
- Full/backpressure: mem_busy=1, push 4 stores -> count=4, st_ready=0. A 5th store held 3 cycles is not accepted. Release mem_busy -> 4 writes in push order on consecutive cycles, and the 5th store is accepted on the cycle after the first pop.
- Forwarding: mem_busy=1, push (0x20,0x11), (0x21,0x22), (0x20,0x33). ld_addr=0x20 -> ld_hit=1, ld_data=0x33. ld_addr=0x21 -> ld_data=0x22. ld_addr=0x22 -> ld_hit=0, ld_data=0.
- Wrap and simultaneous events: with count=3, push and pop together for 10 cycles -> count stays 3, pointers wrap, memory contents match the in-order reference model.
- Reset mid-operation: count=3 with mem_wrt=1, assert rst_n=0 asynchronously -> mem_wrt drops immediately, count=0, and no further memory writes occur.

Source files
------------

// File: rtl/dmem_store_buffer_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the MEM-stage store buffer: byte and address widths
// and the layout of one pending-store entry.
package dmem_store_buffer_pkg;

  localparam int BYTE_W     = 8;
  localparam int MEM_ADDR_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [MEM_ADDR_W-1:0] addr;
    logic [BYTE_W-1:0]     data;
  } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_match.sv
`timescale 1ns/1ps
// Youngest-match search over the pending stores for load forwarding.
// Entries are visited from oldest to youngest relative to tail, so the last
// match written wins and the result is the store closest to tail-1.
module store_buf_match
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0]  entries,
  input  logic [PTR_W-1:0]       tail,
  input  logic [MEM_ADDR_W-1:0]  ld_addr,
  output logic                   hit,
  output logic [BYTE_W-1:0]      data
);

  logic [PTR_W-1:0] idx;

  // Priority search, oldest slot first so younger matches overwrite older ones
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = tail - PTR_W'(i);
      if (entries[idx].valid && (entries[idx].addr == ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
`timescale 1ns/1ps
// In-order store buffer in front of the data memory write port. Stores are
// queued in a circular FIFO and drained one per cycle whenever the port is
// not claimed by a load; loads see the youngest pending store to their address.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = BYTE_W,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  input  logic                       mem_busy,
  output logic                       mem_wrt,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  ent_vld;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  cnt;

  logic              full;
  logic              push;
  logic              pop;

  sb_entry_t [DEPTH-1:0] entries;

  // Full is taken from the registered count only; a pop in the same cycle
  // does not reopen the input until the following cycle.
  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign st_ready = !full;
  assign count    = cnt;

  assign push     = st_valid && st_ready;
  assign mem_wrt  = !empty && !mem_busy;
  assign pop      = mem_wrt;

  assign mem_addr = mem_wrt ? ent_addr[head] : '0;
  assign mem_data = mem_wrt ? ent_data[head] : '0;

  // Pack the entry fields for the forwarding search
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i].valid = ent_vld[i];
      entries[i].addr  = ent_addr[i];
      entries[i].data  = ent_data[i];
    end
  end

  store_buf_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .entries (entries),
    .tail    (tail),
    .ld_addr (ld_addr),
    .hit     (ld_hit),
    .data    (ld_data)
  );

  // Control state: pointers, occupancy and entry-valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (push) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry payload: written at tail on an accepted store, qualified by ent_vld
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr;
      ent_data[tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
`timescale 1ns/1ps
// Bench for dmem_store_buffer: directed stores with a write-order scoreboard.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       st_valid;
  logic [7:0] st_addr;
  logic [7:0] st_data;
  logic       st_ready;
  logic [7:0] ld_addr;
  logic       ld_hit;
  logic [7:0] ld_data;
  logic       mem_busy;
  logic       mem_wrt;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic [2:0] count;
  logic       empty;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  tb_mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_store_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (8),
    .ADDR_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .mem_busy (mem_busy),
    .mem_wrt  (mem_wrt),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .count    (count),
    .empty    (empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a store and hold it until accepted; the expected write is queued.
  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    @(negedge clk);
    while (!st_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: store %0h/%0h never accepted", a, d);
    end else begin
      exp_q.push_back({a, d});
    end
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!empty && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, empty, 1);
  endtask

  // Memory-side monitor: every write must be the oldest outstanding store
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (mem_wrt !== 1'b0) begin
      wr_total++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing pending", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("drain_order", {mem_addr, mem_data}, e);
      end
      tb_mem[mem_addr] = mem_data;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] wrap_exp [5];
    int base;
    wrap_exp = '{8'h5A, 8'h5B, 8'h5C, 8'h58, 8'h59};

    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_addr  = '0;
    mem_busy = 1'b0;
    for (int i = 0; i < 256; i++) tb_mem[i] = '0;

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      tick();
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = 8'($urandom);
      st_data  = 8'($urandom);
      ld_addr  = 8'($urandom);
      mem_busy = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_empty", empty, 1);
      check("rst_count", count, 0);
      check("rst_st_ready", st_ready, 1);
      check("rst_mem_wrt", mem_wrt, 0);
      check("rst_ld_hit", ld_hit, 0);
      check("rst_ld_data", ld_data, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
    end
    tick();
    st_valid = 1'b0;
    mem_busy = 1'b0;
    ld_addr  = '0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_empty", empty, 1);
    check("post_rst_count", count, 0);
    check("post_rst_mem_wrt", mem_wrt, 0);

    // Single store
    tick();
    push(8'h10, 8'hAB);
    @(negedge clk);
    check("single_mem_wrt", mem_wrt, 1);
    check("single_mem_addr", mem_addr, 8'h10);
    check("single_mem_data", mem_data, 8'hAB);
    @(negedge clk);
    check("single_empty", empty, 1);
    check("single_mem_content", tb_mem[8'h10], 8'hAB);

    // Full and backpressure
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i), 8'(8'hC0 + i));
    @(negedge clk);
    check("full_count", count, 4);
    check("full_st_ready", st_ready, 0);
    check("busy_mem_wrt", mem_wrt, 0);
    check("busy_mem_addr", mem_addr, 0);
    check("busy_mem_data", mem_data, 0);
    tick();
    st_valid = 1'b1;
    st_addr  = 8'h44;
    st_data  = 8'hC4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held_st_ready", st_ready, 0);
      check("held_count", count, 4);
    end
    tick();
    mem_busy = 1'b0;
    base = wr_total;
    @(negedge clk);
    check("full_pop_st_ready", st_ready, 0);
    check("full_pop_mem_wrt", mem_wrt, 1);
    push(8'h44, 8'hC4);
    check("fifth_accept_writes", wr_total - base, 2);
    check("fifth_accept_count", count, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("drain_consecutive", mem_wrt, 1);
    end
    @(negedge clk);
    check("drain_done_empty", empty, 1);

    // Forwarding
    tick();
    mem_busy = 1'b1;
    push(8'h20, 8'h11);
    push(8'h21, 8'h22);
    push(8'h20, 8'h33);
    ld_addr = 8'h20;
    @(negedge clk);
    check("fwd20_hit", ld_hit, 1);
    check("fwd20_data", ld_data, 8'h33);
    tick();
    ld_addr = 8'h21;
    @(negedge clk);
    check("fwd21_hit", ld_hit, 1);
    check("fwd21_data", ld_data, 8'h22);
    tick();
    ld_addr = 8'h22;
    @(negedge clk);
    check("fwd22_hit", ld_hit, 0);
    check("fwd22_data", ld_data, 0);
    tick();
    st_valid = 1'b1;
    st_addr  = 8'h22;
    st_data  = 8'h99;
    @(negedge clk);
    check("fwd_same_cycle_hit", ld_hit, 0);
    check("fwd_same_cycle_data", ld_data, 0);
    exp_q.push_back({8'h22, 8'h99});
    tick();
    st_valid = 1'b0;
    @(negedge clk);
    check("fwd_after_push_hit", ld_hit, 1);
    check("fwd_after_push_data", ld_data, 8'h99);
    check("fwd_after_push_count", count, 4);
    tick();
    mem_busy = 1'b0;
    repeat (4) @(negedge clk);
    check("fwd_head_mem_wrt", mem_wrt, 1);
    check("fwd_head_hit", ld_hit, 1);
    check("fwd_head_data", ld_data, 8'h99);
    @(negedge clk);
    check("fwd_drained_empty", empty, 1);
    check("fwd_drained_hit", ld_hit, 0);
    check("fwd_queue_drained", exp_q.size(), 0);

    // Wrap with simultaneous push and pop
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) push(8'(8'h80 + (i % 5)), 8'(8'h50 + i));
    mem_busy = 1'b0;
    for (int i = 3; i < 13; i++) begin
      push(8'(8'h80 + (i % 5)), 8'(8'h50 + i));
      check("wrap_count", count, 3);
    end
    ld_addr = 8'h81;
    @(negedge clk);
    check("wrap_fwd_hit", ld_hit, 1);
    check("wrap_fwd_data", ld_data, 8'h5B);
    wait_empty("wrap_empty");
    for (int i = 0; i < 5; i++) check("wrap_mem_content", tb_mem[8'(8'h80 + i)], wrap_exp[i]);

    // Asynchronous reset while draining
    tick();
    mem_busy = 1'b1;
    push(8'h90, 8'hE0);
    push(8'h91, 8'hE1);
    push(8'h92, 8'hE2);
    mem_busy = 1'b0;
    #2;
    check("midrst_pre_mem_wrt", mem_wrt, 1);
    check("midrst_pre_count", count, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_wrt", mem_wrt, 0);
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_after_count", count, 0);
    check("midrst_after_mem_wrt", mem_wrt, 0);
    for (int i = 0; i < 3; i++) check("midrst_no_write", tb_mem[8'(8'h90 + i)], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
